// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the PLB configuration sequencer.
//   cfg_state_e       : sequencer state encoding
//   HDR_MAGIC_DEFAULT : default header tag expected in bits [15:8]
//   HDR_SYNC_BIT      : header bit carrying the sync/async mux select
//   HDR_CARRY_BIT     : header bit carrying the carry-chain mux select
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } cfg_state_e;

    localparam logic [7:0] HDR_MAGIC_DEFAULT = 8'hA5;
    localparam int         HDR_SYNC_BIT      = 0;
    localparam int         HDR_CARRY_BIT     = 1;

endpackage

// File: rtl/fpga_plb_cfg_ctrl.sv
// Configuration sequencer for one programmable logic block.
// Accepts a header word followed by NUM_LC LUT words, assembles them in a
// shadow register and commits them to the PLB with a single write strobe.
// Ports:
//   clk_i, reset_ni            : clock, synchronous active-low reset
//   start_i                    : start/restart a load (IDLE, DONE, ERR only)
//   cfg_data_i/valid_i/ready_o : configuration word stream handshake
//   run_en_i                   : user flop-enable request
//   plb_config_o               : LUT words (always the shadow contents)
//   plb_config_we_o            : one-cycle commit strobe
//   plb_mux_sync_o/carry_o     : static PLB mux selects, updated at commit
//   plb_dffe_o                 : PLB flop enable, only live in DONE
//   busy_o, done_o, err_o      : status
module fpga_plb_cfg_ctrl
    import fpga_cfg_pkg::*;
#(
    parameter int         NUM_LC    = 8,
    parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     start_i,
    input  logic [15:0]              cfg_data_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic                     run_en_i,
    output logic [NUM_LC-1:0][15:0]  plb_config_o,
    output logic                     plb_config_we_o,
    output logic                     plb_mux_sync_o,
    output logic                     plb_mux_carry_o,
    output logic                     plb_dffe_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int CNT_W = (NUM_LC > 1) ? $clog2(NUM_LC) : 1;
    localparam logic [CNT_W-1:0] LAST_LC = CNT_W'(NUM_LC - 1);

    cfg_state_e              r_state;
    cfg_state_e              w_state_nxt;
    logic [CNT_W-1:0]        r_lc_cnt;
    logic [NUM_LC-1:0][15:0] r_shadow;
    logic                    r_mode_sync;
    logic                    r_mode_carry;
    logic                    r_mux_sync;
    logic                    r_mux_carry;

    // Status outputs are registered from the next-state decode, so each one
    // equals a decode of the current state without any combinational path
    // from the stream inputs.
    logic                    r_ready, r_we, r_busy, r_done, r_err;
    logic                    w_ready_nxt, w_we_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;

    logic                    w_hs;
    logic                    w_hdr_ok;

    assign w_hs     = cfg_valid_i & r_ready;
    assign w_hdr_ok = (cfg_data_i[15:8] == HDR_MAGIC);

    // State register and datapath
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state      <= ST_IDLE;
            r_lc_cnt     <= '0;
            r_shadow     <= '0;
            r_mode_sync  <= 1'b0;
            r_mode_carry <= 1'b0;
            r_mux_sync   <= 1'b0;
            r_mux_carry  <= 1'b0;
            r_ready      <= 1'b0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            r_we    <= w_we_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;

            if (r_state == ST_HDR && w_hs && w_hdr_ok) begin
                r_mode_sync  <= cfg_data_i[HDR_SYNC_BIT];
                r_mode_carry <= cfg_data_i[HDR_CARRY_BIT];
                r_lc_cnt     <= '0;
            end

            if (r_state == ST_LOAD && w_hs) begin
                r_shadow[r_lc_cnt] <= cfg_data_i;
                if (r_lc_cnt != LAST_LC)
                    r_lc_cnt <= r_lc_cnt + 1'b1;
            end

            // Mux selects change together with the commit strobe so the PLB
            // sees the new LUT contents and routing in the same cycle.
            if (w_state_nxt == ST_COMMIT) begin
                r_mux_sync  <= r_mode_sync;
                r_mux_carry <= r_mode_carry;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start_i) w_state_nxt = ST_HDR;
            ST_HDR:    if (w_hs) w_state_nxt = w_hdr_ok ? ST_LOAD : ST_ERR;
            ST_LOAD:   if (w_hs && r_lc_cnt == LAST_LC) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_DONE;
            ST_DONE:   if (start_i) w_state_nxt = ST_HDR;
            ST_ERR:    if (start_i) w_state_nxt = ST_HDR;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state
    always_comb begin
        w_ready_nxt = (w_state_nxt == ST_HDR) || (w_state_nxt == ST_LOAD);
        w_busy_nxt  = w_ready_nxt || (w_state_nxt == ST_COMMIT);
        w_we_nxt    = (w_state_nxt == ST_COMMIT);
        w_done_nxt  = (w_state_nxt == ST_DONE);
        w_err_nxt   = (w_state_nxt == ST_ERR);
    end

    assign cfg_ready_o     = r_ready;
    assign plb_config_o    = r_shadow;
    assign plb_config_we_o = r_we;
    assign plb_mux_sync_o  = r_mux_sync;
    assign plb_mux_carry_o = r_mux_carry;
    assign plb_dffe_o      = r_done & run_en_i;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign err_o           = r_err;

endmodule
